uart_tx_param: RTL and testbench

//  Parametrised UART transmitter: buffered write port, runtime-configurable word length,

---
 rtl/uart_tx_param_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_tx_param.sv | 108 ++++++++++
 tb/tb_uart_tx_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_param_pkg.sv
// uart_tx_param_pkg: shared types and helpers for the parametrised UART transmitter.
package uart_tx_param_pkg;

    localparam int MAX_DIV_W = 16;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

    typedef struct packed {
        logic [MAX_DIV_W-1:0] br_div;
        logic [3:0]           data_bits;
        parity_t              parity;
        logic                 stop2;
    } tx_frame_cfg_t;

    function automatic logic [3:0] clamp_bits(input logic [3:0] b, input logic [3:0] max_bits);
        return b < 4'd5 ? 4'd5 : (b > max_bits ? max_bits : b);
    endfunction

    function automatic parity_t to_parity(input logic [1:0] p);
        return p == 2'b01 ? PAR_EVEN : (p == 2'b10 ? PAR_ODD : PAR_NONE);
    endfunction

    function automatic logic data_parity(input logic [15:0] d, input logic [3:0] n, input parity_t p);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 16; i++)
            if (i < int'(n)) x ^= d[i];
        return p == PAR_ODD ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with clear, registered occupancy and full/empty flags.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk)
        if (do_push && !clr) mem[wptr] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter with per-frame latched word length,
// parity, stop bits and baud divisor; frames stream back-to-back while data is buffered.
module uart_tx_param
    import uart_tx_param_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_en,
    input  logic [DIV_W-1:0]              cfg_br_div,
    input  logic [3:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          fifo_clr,
    input  logic                          wr_valid,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          txd,
    output logic                          busy,
    output logic                          txf,
    output logic                          txe,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    tx_state_t         state, nxt;
    tx_frame_cfg_t     frm;
    logic [DATA_W-1:0] head, shreg;
    logic [DIV_W-1:0]  baud;
    logic [3:0]        bit_cnt, n_cfg;
    logic              par, bit_end, last_bit, last_stop, load;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (wr_valid && !txf),
        .pop   (load),
        .wdata (wr_data),
        .rdata (head),
        .full  (txf),
        .empty (txe),
        .level (level)
    );

    assign wr_ready  = !txf;
    assign busy      = state != TX_IDLE;
    assign n_cfg     = clamp_bits(cfg_data_bits, 4'(DATA_W));
    assign bit_end   = baud == '0;
    assign last_bit  = bit_cnt == frm.data_bits - 4'd1;
    assign last_stop = state == TX_STOP && bit_end && bit_cnt == 4'd0;
    // A new frame may start from idle or seamlessly on the last clock of the final stop bit.
    assign load      = cfg_en && !txe && (state == TX_IDLE || last_stop);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= TX_IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            TX_IDLE:   nxt = load ? TX_START : TX_IDLE;
            TX_START:  nxt = bit_end ? TX_DATA : TX_START;
            TX_DATA:   nxt = (bit_end && last_bit) ? (frm.parity == PAR_NONE ? TX_STOP : TX_PARITY) : TX_DATA;
            TX_PARITY: nxt = bit_end ? TX_STOP : TX_PARITY;
            TX_STOP:   nxt = last_stop ? (load ? TX_START : TX_IDLE) : TX_STOP;
            default:   nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm     <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            baud    <= '0;
            bit_cnt <= '0;
            txd     <= 1'b1;
        end else if (load) begin
            frm     <= '{br_div: MAX_DIV_W'(cfg_br_div), data_bits: n_cfg,
                         parity: to_parity(cfg_parity), stop2: cfg_stop2};
            shreg   <= head;
            par     <= data_parity(16'(head), n_cfg, to_parity(cfg_parity));
            baud    <= cfg_br_div;
            bit_cnt <= '0;
            txd     <= 1'b0;
        end else if (busy && bit_end) begin
            baud <= frm.br_div[DIV_W-1:0];
            case (nxt)
                TX_DATA: begin
                    txd     <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_cnt <= state == TX_DATA ? bit_cnt + 4'd1 : 4'd0;
                end
                TX_PARITY: txd <= par;
                TX_STOP: begin
                    txd     <= 1'b1;
                    bit_cnt <= state == TX_STOP ? bit_cnt - 4'd1 : {3'b0, frm.stop2};
                end
                default: txd <= 1'b1;
            endcase
        end else if (busy) begin
            baud <= baud - DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed and randomized frames checked clock-by-clock against
// a serial waveform model built from the frame format rules.
module tb_uart_tx_param;
    logic        clk = 1'b0;
    logic        rst_n, cfg_en, cfg_stop2, fifo_clr, wr_valid;
    logic [15:0] cfg_br_div;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic [8:0]  wr_data;
    logic        wr_ready, txd, busy, txf, txe;
    logic [3:0]  level;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];
    logic [8:0] burst[9];

    uart_tx_param #(.DATA_W(9), .FIFO_DEPTH(8), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_br_div(cfg_br_div),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .fifo_clr(fifo_clr), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .txd(txd), .busy(busy), .txf(txf), .txe(txe), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected txd per clock: start, N data bits LSB first, optional parity, stop bits.
    task automatic add_frame(input logic [8:0] d, input int nb, input int pm, input bit s2, input int div);
        int n;
        int ones;
        bit b[$];
        n = nb < 5 ? 5 : (nb > 9 ? 9 : nb);
        ones = 0;
        b.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            b.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pm == 1) b.push_back(bit'(ones % 2));
        if (pm == 2) b.push_back(bit'(1 - ones % 2));
        b.push_back(1'b1);
        if (s2) b.push_back(1'b1);
        foreach (b[j])
            repeat (div + 1) exp_q.push_back(b[j]);
    endtask

    task automatic set_cfg(input int div, input int nb, input int pm, input bit s2);
        cfg_br_div    = 16'(div);
        cfg_data_bits = 4'(nb);
        cfg_parity    = 2'(pm);
        cfg_stop2     = s2;
    endtask

    task automatic wr(input logic [8:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("pre_start_txd", txd, 1);
        chk("post_write_level", level, 1);
    endtask

    task automatic run_stream(input int clr_at, input int pre_lvl, input bit scramble);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("txd", txd, exp_q[i]);
            chk("busy", busy, 1);
            if (scramble && i == 0)
                set_cfg($urandom_range(0, 9), $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom));
            if (i == clr_at) begin
                chk("pre_clr_level", level, pre_lvl);
                fifo_clr = 1'b1;
            end else if (i == clr_at + 1) begin
                fifo_clr = 1'b0;
                chk("clr_level", level, 0);
                chk("clr_txe", txe, 1);
            end
        end
        exp_q.delete();
        @(negedge clk);
        chk("end_txd", txd, 1);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        int div, nb, pm;
        bit s2;
        logic [8:0] d;
        rst_n = 1'b0; cfg_en = 1'b0; fifo_clr = 1'b0; wr_valid = 1'b0; wr_data = '0;
        set_cfg(0, 8, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_txe", txe, 1);
        chk("rst_txf", txf, 0);
        chk("rst_level", level, 0);
        chk("rst_wr_ready", wr_ready, 1);
        rst_n = 1'b1;

        // 8N1, divisor 3, 0xA5: 40 clocks
        cfg_en = 1'b1;
        set_cfg(3, 8, 0, 0);
        wr(9'h0A5);
        add_frame(9'h0A5, 8, 0, 0, 3);
        chk("frame_8n1_len", exp_q.size(), 40);
        run_stream(-5, 0, 0);

        // 7E2, divisor 0, 0x41: 11 clocks
        set_cfg(0, 7, 1, 1);
        wr(9'h041);
        add_frame(9'h041, 7, 1, 1, 0);
        run_stream(-5, 0, 0);

        // 9-bit odd parity and 8-bit odd of zero
        set_cfg(1, 9, 2, 0);
        wr(9'h1FF);
        add_frame(9'h1FF, 9, 2, 0, 1);
        run_stream(-5, 0, 0);
        set_cfg(0, 8, 2, 0);
        wr(9'h000);
        add_frame(9'h000, 8, 2, 0, 0);
        run_stream(-5, 0, 0);

        // Randomized single frames, with config scrambled mid-frame
        for (int k = 0; k < 24; k++) begin
            div = $urandom_range(0, 4);
            nb  = $urandom_range(0, 15);
            pm  = $urandom_range(0, 3);
            s2  = 1'($urandom);
            d   = 9'($urandom);
            set_cfg(div, nb, pm, s2);
            wr(d);
            add_frame(d, nb, pm, s2, div);
            run_stream(-5, 0, 1);
        end

        // Fill buffer while disabled, then stream 8 frames back-to-back
        cfg_en = 1'b0;
        div = $urandom_range(0, 2); nb = $urandom_range(5, 9); pm = $urandom_range(0, 3); s2 = 1'($urandom);
        set_cfg(div, nb, pm, s2);
        for (int i = 0; i < 9; i++) begin
            burst[i] = 9'($urandom);
            @(negedge clk);
            chk("burst_wr_ready", wr_ready, (i < 8) ? 1 : 0);
            wr_valid = 1'b1;
            wr_data  = burst[i];
        end
        @(negedge clk);
        wr_valid = 1'b0;
        chk("full_level", level, 8);
        chk("full_txf", txf, 1);
        chk("full_wr_ready", wr_ready, 0);
        chk("full_idle", busy, 0);
        for (int i = 0; i < 8; i++) add_frame(burst[i], nb, pm, s2, div);
        cfg_en = 1'b1;
        run_stream(-5, 0, 0);
        chk("drain_txe", txe, 1);
        chk("drain_level", level, 0);

        // Clear buffer while a frame is in flight with 3 entries queued
        cfg_en = 1'b0;
        set_cfg(1, 8, 1, 0);
        for (int i = 0; i < 4; i++) begin
            burst[i] = 9'($urandom);
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = burst[i];
        end
        @(negedge clk);
        wr_valid = 1'b0;
        chk("clr_pre_fill", level, 4);
        add_frame(burst[0], 8, 1, 0, 1);
        cfg_en = 1'b1;
        run_stream(5, 3, 0);
        chk("clr_after_txe", txe, 1);

        // Asynchronous reset during a start bit with data buffered
        set_cfg(2, 8, 0, 0);
        wr(9'h03C);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 9'h055;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("pre_rst_txd", txd, 0);
        chk("pre_rst_level", level, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_txd", txd, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_txe", txe, 1);
        chk("async_rst_level", level, 0);
        chk("async_rst_wr_ready", wr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_txd", txd, 1);
            chk("post_rst_busy", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
